// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with valid/ready handshake and a
// precise trap on signed overflow (faulting instruction squashed, PC kept in epc).
module ex_mem_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [WIDTH-1:0] Alures,
    input  logic             Zero,
    input  logic             Neg,
    input  logic             ovfalu,
    input  logic             ovf_en,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [REGW-1:0]  ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_memwrite,
    input  logic [WIDTH-1:0] ex_wdata,
    input  logic             flush,
    input  logic             mem_ready,
    output logic             mem_valid,
    output logic [WIDTH-1:0] mem_alures,
    output logic             mem_zero,
    output logic             mem_neg,
    output logic [WIDTH-1:0] mem_pc,
    output logic [REGW-1:0]  mem_rd,
    output logic             mem_regwrite,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             exc_req,
    input  logic             exc_ack,
    output logic [WIDTH-1:0] epc,
    output logic [CNTW-1:0]  ovf_count
);
    typedef enum logic {RUN, TRAP} state_t;
    state_t state;
    logic accept, fault, drain;
    assign ex_ready = (state == RUN) && (!mem_valid || mem_ready);
    assign accept   = ex_valid && ex_ready && !flush;
    assign fault    = ovfalu && ovf_en;
    assign drain    = mem_valid && mem_ready;
    assign exc_req  = (state == TRAP);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            mem_valid    <= 1'b0;
            mem_alures   <= '0;
            mem_zero     <= 1'b0;
            mem_neg      <= 1'b0;
            mem_pc       <= '0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_wdata    <= '0;
            epc          <= '0;
            ovf_count    <= '0;
        end else begin
            if (flush) begin
                mem_valid    <= 1'b0;
                mem_regwrite <= 1'b0;
                mem_memread  <= 1'b0;
                mem_memwrite <= 1'b0;
            end else if (accept && !fault) begin
                mem_valid    <= 1'b1;
                mem_alures   <= Alures;
                mem_zero     <= Zero;
                mem_neg      <= Neg;
                mem_pc       <= ex_pc;
                mem_rd       <= ex_rd;
                mem_regwrite <= ex_regwrite;
                mem_memread  <= ex_memread;
                mem_memwrite <= ex_memwrite;
                mem_wdata    <= ex_wdata;
            end else if (drain) begin
                mem_valid <= 1'b0;
            end
            // a faulting accept never loads mem_*; it only arms the trap
            if (accept && fault) begin
                epc   <= ex_pc;
                state <= TRAP;
                if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
            end else if (state == TRAP && exc_ack) begin
                state <= RUN;
            end
        end
    end
endmodule
